// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with prioritised redirects
// (exception, exception return, branch) and an exception PC register.
// Optional return-address stack, built only when macro PC_RAS_EN is defined.
module pc_unit #(
  parameter int                 PC_WIDTH   = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                 PC_INC     = 1,
  parameter logic [PC_WIDTH-1:0] EXC_VECTOR = 'h0004,
  parameter int                 RAS_DEPTH  = 4
) (
  input  logic                clk_50Mhz,
  input  logic                rst,
  input  logic                PC_pause,
  input  logic                exc_valid,
  input  logic                eret_valid,
  input  logic                branch_valid,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                call_push,
  input  logic                ret_pop,
  output logic [PC_WIDTH-1:0] PC_out,
  output logic [PC_WIDTH-1:0] EPC_out,
  output logic                ras_empty,
  output logic                ras_full
);

  localparam logic [PC_WIDTH-1:0] INC_W = PC_WIDTH'(PC_INC);

  logic [PC_WIDTH-1:0] pc_q, pc_d, epc_q, epc_d, pc_seq;

  // Sequential successor; also the value pushed as a return address.
  assign pc_seq = pc_q + INC_W;

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(RAS_DEPTH);

  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]       ptr_q, ptr_d, top_idx, ras_widx;
  logic [PW:0]         cnt_q, cnt_d;
  logic                ras_we;

  // ptr_q addresses the next free slot, so the top entry sits one below it.
  // When full, ptr_q lands on the oldest entry and a push overwrites it.
  assign top_idx = ptr_q - PW'(1);

  // Next-PC priority chain and RAS bookkeeping.
  always_comb begin
    pc_d     = pc_seq;
    epc_d    = epc_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ras_we   = 1'b0;
    ras_widx = ptr_q;
    if (exc_valid) begin
      pc_d  = EXC_VECTOR;
      epc_d = pc_q;
    end else if (eret_valid) begin
      pc_d = epc_q;
    end else if (branch_valid) begin
      pc_d = branch_target;
    end else if (PC_pause) begin
      pc_d = pc_q;
    end else if (ret_pop && (cnt_q != '0)) begin
      pc_d = ras_mem[top_idx];
      if (call_push) begin
        // Pop and push together: replace the top in place.
        ras_we   = 1'b1;
        ras_widx = top_idx;
      end else begin
        ptr_d = top_idx;
        cnt_d = cnt_q - 1'b1;
      end
    end else if (call_push) begin
      ras_we   = 1'b1;
      ras_widx = ptr_q;
      ptr_d    = ptr_q + PW'(1);
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
    end
  end

  // RAS pointer and count registers.
  always_ff @(posedge clk_50Mhz) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // RAS storage; contents need no reset because count gates every read.
  always_ff @(posedge clk_50Mhz) begin
    if (!rst && ras_we) ras_mem[ras_widx] <= pc_seq;
  end

  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_FULL);
`else
  logic unused_ras;
  assign unused_ras = call_push ^ ret_pop;

  // Next-PC priority chain without return prediction.
  always_comb begin
    pc_d  = pc_seq;
    epc_d = epc_q;
    if (exc_valid) begin
      pc_d  = EXC_VECTOR;
      epc_d = pc_q;
    end else if (eret_valid) begin
      pc_d = epc_q;
    end else if (branch_valid) begin
      pc_d = branch_target;
    end else if (PC_pause) begin
      pc_d = pc_q;
    end
  end

  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
`endif

  // PC and EPC registers; reset wins over every request.
  always_ff @(posedge clk_50Mhz) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      epc_q <= RESET_PC;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
    end
  end

  assign PC_out  = pc_q;
  assign EPC_out = epc_q;

endmodule
